text_write_arbiter: RTL and testbench
=====================================

Name: text_write_arbiter

Overview:
Shares the single write port of the on-screen character memory (80x30 = 2400 cells, 8x16 font, 640x480) between several writers, such as the number formatter and the MIDI note/velocity display logic.
- Each requester uses a valid/ready handshake.
- A round-robin arbiter grants one write per cycle.
- A built-in clear engine fills the whole screen with one character.
- Sits between the text producers and the character memory read by the text-mode renderer.

Parameters:
REQS, 4, number of requesters
CHARS, 2400, number of character cells (charsH*charsV)
IDX_W, 12, cell index width ($clog2(CHARS))
CHAR_W, 8, character code width
FILL_CHAR, 2, code written by the clear engine (space glyph)

Ports:
clk  in  1  system clock (10 MHz)
rst  in  1  asynchronous, active-high reset
req_valid  in  REQS  per-requester write request
req_idx  in  REQS*IDX_W  per-requester cell index (y*charsH + x)
req_char  in  REQS*CHAR_W  per-requester character code
req_ready  out  REQS  one-hot grant; transfer when valid&ready
clear_start  in  1  pulse: start full-screen clear
busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse after the last clear write
wr_en  out  1  memory write strobe
wr_idx  out  IDX_W  memory write address
wr_char  out  CHAR_W  memory write data
oob_flag  out  1  sticky: request with idx >= CHARS was seen

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. On reset:
  - FSM goes to IDLE.
  - RR pointer = REQS-1, so requester 0 has first priority.
  - All outputs = 0.
- FSM states:
  - IDLE: arbitrate requesters.
  - CLEAR: sequential fill.
- IDLE arbitration:
  - req_ready is combinational from req_valid and the RR pointer; at most one bit is set.
  - The search starts at pointer+1 mod REQS.
  - The pointer updates to the winner only on a grant; otherwise it holds.
- Requester obligations: hold valid/idx/char stable until ready. Deasserting valid before ready is permitted; the request is simply withdrawn.
- Write latency:
  - The granted request appears on wr_en/wr_idx/wr_char on the next clock edge (registered, 1 cycle).
  - Maximum throughput is one write per cycle.
- Out-of-range index: a granted request with idx >= CHARS is acknowledged but dropped (wr_en=0), and oob_flag is set. oob_flag clears only on rst.
- Clear start:
  - clear_start in IDLE moves to CLEAR at the next edge with counter=0 and busy=1.
  - If clear_start and requests arrive in the same cycle, clear wins and no grant is issued.
- CLEAR:
  - req_ready=0.
  - Each cycle: wr_en=1, wr_idx=counter, wr_char=FILL_CHAR; counter increments.
  - After writing CHARS-1: return to IDLE, busy=0, clear_done=1 for exactly one cycle. The counter never wraps past CHARS-1.
  - clear_start while in CLEAR is ignored; it does not restart the clear.
  - Full clear therefore takes CHARS cycles from the first write to the last.
- Reset mid-clear: immediate return to IDLE with all outputs 0. No clear_done. Memory is left partially cleared.
- Idle with no requests: wr_en=0; wr_idx/wr_char hold their last values.

Optional Feature:
TEXT_ARB_VBLANK_EN
- When defined:
  - Adds input port vblank (1 bit), high during the vertical blanking interval.
  - Grants occur only when vblank=1; req_ready is forced 0 otherwise.
  - CLEAR writes only when vblank=1; otherwise it pauses with the counter and busy held.
  - Result: writes never tear a visible frame.
- When undefined: there is no vblank port, and writes proceed in any cycle.

Decomposition:
- Package PKGTextArb holds:
  - Constants REQS and FILL_CHAR.
  - IDX_W and CHAR_W, derived from PKGVideo::bitsChars and PKGFont::bitsChar.
  - typedef struct packed {idx; char} text_wr_t, used for the requester and write buses.
  - enum state_t {IDLE, CLEAR}.
- One sub-module, rr_arbiter:
  - Parameterised REQS.
  - Inputs: valid vector, enable, clk, rst.
  - Outputs: one-hot grant.
  - Owns the pointer register.

Test Plan:
- Reset, then req_valid=4'b0001, idx=243, char=5 -> req_ready=0001 the same cycle; next cycle wr_en=1, wr_idx=243, wr_char=5.
- All four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; wr_en high for 8 consecutive cycles.
- req1 idx=2400 -> ready asserted, wr_en stays 0, oob_flag=1 and stays 1 until rst.
- clear_start together with req0 valid:
  - req_ready stays 0 throughout.
  - Writes idx 0..2399 with char 2 over 2400 cycles.
  - clear_done pulses once; req0 is granted the cycle after returning to IDLE.
- rst asserted at clear write 1000 -> outputs 0 asynchronously, busy=0, no clear_done; a subsequent clear_start restarts at idx 0.
- With TEXT_ARB_VBLANK_EN: vblank=0 with req0 valid -> no grant; vblank=1 -> grant. During CLEAR, vblank low for 10 cycles -> counter holds and resumes at the same idx.

Source files
------------

// File: rtl/text_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// text_write_arbiter_pkg
// Shared constants and types for the character-memory write arbiter.
//   - Screen geometry: 80x30 character cells (8x16 font on 640x480).
//   - TA_IDX_W : cell index width, derived from the cell count.
//   - TA_CHAR_W: character code width of the font ROM.
//   - text_wr_t: one write (cell index + character code).
//   - state_t  : arbiter FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package text_write_arbiter_pkg;

  // Video / font geometry
  localparam int TA_CHARS_H   = 80;
  localparam int TA_CHARS_V   = 30;
  localparam int TA_CHARS     = TA_CHARS_H * TA_CHARS_V;
  localparam int TA_BITS_CHARS = $clog2(TA_CHARS);
  localparam int TA_BITS_CHAR  = 8;

  // Arbiter configuration
  localparam int TA_REQS   = 4;
  localparam int TA_IDX_W  = TA_BITS_CHARS;
  localparam int TA_CHAR_W = TA_BITS_CHAR;
  localparam logic [TA_CHAR_W-1:0] TA_FILL_CHAR = 8'd2;  // space glyph

  typedef struct packed {
    logic [TA_IDX_W-1:0]  idx;
    logic [TA_CHAR_W-1:0] chr;
  } text_wr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // True when the index addresses an existing cell.
  function automatic logic idx_in_range(input logic [TA_IDX_W-1:0] idx,
                                        input int                  chars);
    return {1'b0, idx} < (TA_IDX_W + 1)'(chars);
  endfunction

endpackage

// File: rtl/text_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer.
// The search for a winner starts one position after the last winner, so
// after reset (pointer = REQS-1) requester 0 has first priority. The pointer
// moves to the winner only when a grant is actually issued.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   valid_i   : per-requester request vector
//   en_i      : grant enable; when low no grant is issued and pointer holds
//   grant_o   : one-hot grant (combinational)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int REQS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REQS-1:0] valid_i,
  input  logic            en_i,
  output logic [REQS-1:0] grant_o
);

  localparam int PTR_W = (REQS > 1) ? $clog2(REQS) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] cand_p;
  logic             found;
  int               cand;

  // Rotating priority search: first valid requester after the pointer.
  always_comb begin
    win    = ptr_q;
    found  = 1'b0;
    cand   = 0;
    cand_p = '0;
    for (int off = 1; off <= REQS; off++) begin
      cand   = (int'(ptr_q) + off) % REQS;
      cand_p = PTR_W'(cand);
      if (!found && valid_i[cand_p]) begin
        found = 1'b1;
        win   = cand_p;
      end
    end
  end

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    if (en_i && found) begin
      grant_o[win] = 1'b1;
      ptr_d        = win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= PTR_W'(REQS - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/text_write_arbiter.sv
// -----------------------------------------------------------------------------
// text_write_arbiter
// Shares the single write port of the on-screen character memory between
// several text producers and provides a full-screen clear engine.
//
// Handshake (all requesters): a requester raises req_valid[i] with stable
// req_idx/req_char; the transfer happens in the cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational and at most one-hot.
// A requester may drop valid before ready to withdraw its request.
//
// Ports:
//   clk, rst     : 10 MHz clock, asynchronous active-high reset
//   vblank       : (TEXT_ARB_VBLANK_EN only) writes allowed only while high
//   req_valid    : per-requester write request
//   req_idx      : per-requester cell index (y*80 + x), packed REQS*IDX_W
//   req_char     : per-requester character code, packed REQS*CHAR_W
//   req_ready    : one-hot grant
//   clear_start  : pulse, start filling the whole screen with FILL_CHAR
//   busy         : clear in progress
//   clear_done   : one-cycle pulse after the last clear write
//   wr_en/wr_idx/wr_char : registered memory write port (1-cycle latency)
//   oob_flag     : sticky, a granted request had idx >= CHARS
//   dbg_state    : current FSM state
//
// Optional feature macro: TEXT_ARB_VBLANK_EN (adds vblank gating of all
// writes). Without it every cycle may write.
// IDX_W/CHAR_W come from the package; CHARS must not exceed 2**IDX_W.
// -----------------------------------------------------------------------------
module text_write_arbiter
  import text_write_arbiter_pkg::*;
#(
  parameter int                    REQS      = TA_REQS,
  parameter int                    CHARS     = TA_CHARS,
  parameter logic [TA_CHAR_W-1:0]  FILL_CHAR = TA_FILL_CHAR
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef TEXT_ARB_VBLANK_EN
  input  logic                      vblank,
`endif
  input  logic [REQS-1:0]           req_valid,
  input  logic [REQS*TA_IDX_W-1:0]  req_idx,
  input  logic [REQS*TA_CHAR_W-1:0] req_char,
  output logic [REQS-1:0]           req_ready,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      clear_done,
  output logic                      wr_en,
  output logic [TA_IDX_W-1:0]       wr_idx,
  output logic [TA_CHAR_W-1:0]      wr_char,
  output logic                      oob_flag,
  output state_t                    dbg_state
);

  localparam logic [TA_IDX_W-1:0] LAST_IDX = TA_IDX_W'(CHARS - 1);

  state_t              state_q, state_d;
  logic [TA_IDX_W-1:0] cnt_q, cnt_d;
  text_wr_t            wr_q, wr_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                oob_q, oob_d;

  logic [REQS-1:0]     grant;
  logic                arb_en;
  logic                wr_ok;
  text_wr_t            sel;

`ifdef TEXT_ARB_VBLANK_EN
  assign wr_ok = vblank;
`else
  assign wr_ok = 1'b1;
`endif

  // Grants only in IDLE; a simultaneous clear_start takes precedence.
  // rst is included so req_ready is 0 while reset is held.
  assign arb_en = (state_q == IDLE) && !clear_start && wr_ok && !rst;

  rr_arbiter #(
    .REQS (REQS)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .valid_i (req_valid),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  // Winner data mux (grant is one-hot).
  always_comb begin
    sel = '0;
    for (int i = 0; i < REQS; i++) begin
      if (grant[i]) begin
        sel.idx = req_idx[i*TA_IDX_W +: TA_IDX_W];
        sel.chr = req_char[i*TA_CHAR_W +: TA_CHAR_W];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_start) state_d = CLEAR;
      CLEAR:   if (wr_ok && (cnt_q == LAST_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    req_ready = grant;
    cnt_d     = cnt_q;
    wr_d      = wr_q;     // address/data hold when nothing is written
    wr_en_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    oob_d     = oob_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          cnt_d  = '0;
          busy_d = 1'b1;
        end else if (|grant) begin
          if (idx_in_range(sel.idx, CHARS)) begin
            wr_en_d = 1'b1;
            wr_d    = sel;
          end else begin
            // Acknowledged but dropped; remember that it happened.
            oob_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        // clear_start is ignored here; the fill never restarts.
        if (wr_ok) begin
          wr_en_d = 1'b1;
          wr_d.idx = cnt_q;
          wr_d.chr = FILL_CHAR;
          if (cnt_q == LAST_IDX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy       = busy_q;
  assign clear_done = done_q;
  assign wr_en      = wr_en_q;
  assign wr_idx     = wr_q.idx;
  assign wr_char    = wr_q.chr;
  assign oob_flag   = oob_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_text_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_text_write_arbiter
// Drives text_write_arbiter with directed and random traffic. A reference
// model (round-robin search from last winner, clear as a cycle countdown)
// predicts req_ready/busy/clear_done/oob_flag each cycle and pushes expected
// memory writes into exp_q; a monitor pops and compares on every wr_en.
// -----------------------------------------------------------------------------
module tb_text_write_arbiter;

  localparam int REQS   = 4;
  localparam int CHARS  = 2400;
  localparam int IDX_W  = 12;
  localparam int CHAR_W = 8;
  localparam logic [CHAR_W-1:0] FILL = 8'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #50 clk = ~clk;

  logic [REQS-1:0]        req_valid = '0;
  logic [REQS*IDX_W-1:0]  req_idx   = '0;
  logic [REQS*CHAR_W-1:0] req_char  = '0;
  logic                   clear_start = 1'b0;
  logic                   vblank = 1'b1;
  logic [REQS-1:0]        req_ready;
  logic                   busy, clear_done, wr_en, oob_flag;
  logic [IDX_W-1:0]       wr_idx;
  logic [CHAR_W-1:0]      wr_char;
  text_write_arbiter_pkg::state_t dbg_state;

  text_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
`ifdef TEXT_ARB_VBLANK_EN
    .vblank      (vblank),
`endif
    .req_valid   (req_valid),
    .req_idx     (req_idx),
    .req_char    (req_char),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .busy        (busy),
    .clear_done  (clear_done),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_char     (wr_char),
    .oob_flag    (oob_flag),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [IDX_W+CHAR_W-1:0] exp_q[$];
  int   m_ptr = REQS - 1;
  int   m_clr = 0;        // clear cycles still to write
  logic m_oob = 1'b0;
  logic m_done = 1'b0;
  int   t_idx[REQS];
  int   t_chr[REQS];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check status outputs, advance the model.
  task automatic step(input logic [REQS-1:0] v, input logic cs, input logic vb,
                      output logic [REQS-1:0] gr);
    logic [REQS-1:0] er;
    int w;
    @(posedge clk);
    #5;
    req_valid   = v;
    clear_start = cs;
    vblank      = vb;
    for (int i = 0; i < REQS; i++) begin
      req_idx[i*IDX_W +: IDX_W]    = IDX_W'(t_idx[i]);
      req_char[i*CHAR_W +: CHAR_W] = CHAR_W'(t_chr[i]);
    end
    #5;
    check("busy", int'(busy), int'(m_clr > 0));
    check("clear_done", int'(clear_done), int'(m_done));
    check("oob_flag", int'(oob_flag), int'(m_oob));
    m_done = 1'b0;
    er = '0;
    if (m_clr > 0) begin
      if (vblank) begin
        m_clr--;
        if (m_clr == 0) m_done = 1'b1;
      end
    end else if (cs) begin
      m_clr = CHARS;
      for (int k = 0; k < CHARS; k++) exp_q.push_back({IDX_W'(k), FILL});
    end else if (vblank) begin
      w = -1;
      for (int o = 1; o <= REQS; o++)
        if (w < 0 && v[(m_ptr + o) % REQS]) w = (m_ptr + o) % REQS;
      if (w >= 0) begin
        er[w] = 1'b1;
        m_ptr = w;
        if (t_idx[w] < CHARS) exp_q.push_back({IDX_W'(t_idx[w]), CHAR_W'(t_chr[w])});
        else m_oob = 1'b1;
      end
    end
    check("req_ready", int'(req_ready), int'(er));
    gr = er;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #20 rst = 1'b1;
    #10;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_idx", int'(wr_idx), 0);
    check("rst_wr_char", int'(wr_char), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clear_done", int'(clear_done), 0);
    check("rst_oob_flag", int'(oob_flag), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_state", int'(dbg_state), 0);
    exp_q.delete();
    m_ptr = REQS - 1;
    m_clr = 0;
    m_oob = 1'b0;
    m_done = 1'b0;
    #10 rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [IDX_W+CHAR_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && wr_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: idx %0d char %0d with nothing expected", wr_idx, wr_char);
        end else begin
          e = exp_q.pop_front();
          check("wr_idx", int'(wr_idx), int'(e[IDX_W+CHAR_W-1:CHAR_W]));
          check("wr_char", int'(wr_char), int'(e[CHAR_W-1:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [REQS-1:0] g, v, pend;
    logic vb;
    for (int i = 0; i < REQS; i++) begin
      t_idx[i] = 0;
      t_chr[i] = 0;
    end
    do_reset();

    // Single write from requester 0
    t_idx[0] = 243; t_chr[0] = 5;
    step(4'b0001, 1'b0, 1'b1, g);
    step(4'b0000, 1'b0, 1'b1, g);

    // All requesters valid: rotating grants, back-to-back writes
    for (int i = 0; i < REQS; i++) begin
      t_idx[i] = 100 * i + 7;
      t_chr[i] = 10 + i;
    end
    repeat (8) step(4'b1111, 1'b0, 1'b1, g);
    step(4'b0000, 1'b0, 1'b1, g);

    // Out-of-range index: acknowledged, dropped, sticky flag
    t_idx[1] = 2400; t_chr[1] = 9;
    step(4'b0010, 1'b0, 1'b1, g);
    repeat (3) step(4'b0000, 1'b0, 1'b1, g);

`ifdef TEXT_ARB_VBLANK_EN
    // No grant outside vblank, grant inside
    t_idx[0] = 12; t_chr[0] = 34;
    step(4'b0001, 1'b0, 1'b0, g);
    step(4'b0001, 1'b0, 1'b1, g);
    step(4'b0000, 1'b0, 1'b1, g);
`endif

    // Clear together with a pending req0; req0 waits for the clear to end
    t_idx[0] = 55; t_chr[0] = 66;
    step(4'b0001, 1'b1, 1'b1, g);
    for (int k = 0; k < CHARS + 2; k++) begin
      vb = 1'b1;
`ifdef TEXT_ARB_VBLANK_EN
      vb = !(k >= 500 && k < 510);
`endif
      step(4'b0001, (k == 100), vb, g);  // mid-clear start is ignored
    end
    step(4'b0000, 1'b0, 1'b1, g);

    // Reset in the middle of a clear, then a fresh clear from index 0
    step(4'b0000, 1'b1, 1'b1, g);
    repeat (1000) step(4'b0000, 1'b0, 1'b1, g);
    do_reset();
    repeat (5) step(4'b0000, 1'b0, 1'b1, g);
    step(4'b0000, 1'b1, 1'b1, g);
    repeat (CHARS + 1) step(4'b0000, 1'b0, 1'b1, g);

    // Random traffic; pending requests stay stable or withdraw
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < REQS; i++) begin
        if (pend[i]) begin
          v[i] = ($urandom_range(0, 9) != 0);
        end else begin
          v[i] = 1'($urandom_range(0, 1));
          if (v[i]) begin
            t_idx[i] = int'($urandom_range(0, 2520));
            t_chr[i] = int'($urandom_range(0, 255));
          end
        end
      end
      vb = 1'b1;
`ifdef TEXT_ARB_VBLANK_EN
      vb = ($urandom_range(0, 3) != 0);
`endif
      step(v, (c == 350), vb, g);
      pend = v & ~g;
    end

    // Drain any running clear, bounded
    for (int k = 0; k < 12000 && m_clr > 0; k++) begin
      vb = 1'b1;
`ifdef TEXT_ARB_VBLANK_EN
      vb = ($urandom_range(0, 3) != 0);
`endif
      step(4'b0000, 1'b0, vb, g);
    end
    repeat (3) step(4'b0000, 1'b0, 1'b1, g);
    check("pending_writes", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
